// File: rtl/vector_lane_sequencer.sv
// vector_lane_sequencer: streams captured 256-bit vector operands lane by lane through the
// shared scalar ALU and reassembles the per-lane results for vector writeback.
module vector_lane_sequencer #(
   parameter int LANE_W = 32,
   parameter int LANES  = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   input  logic                      flush_i,
   input  logic [LANE_W*LANES-1:0]   vrs1_i,
   input  logic [LANE_W*LANES-1:0]   vrs2_i,
   input  logic [2:0]                aluop_i,
   input  logic [4:0]                rd_i,
   output logic [LANE_W-1:0]         lane_a_o,
   output logic [LANE_W-1:0]         lane_b_o,
   output logic [2:0]                lane_op_o,
   output logic                      lane_valid_o,
   input  logic [LANE_W-1:0]         lane_result_i,
   output logic                      stall_o,
   output logic [LANE_W*LANES-1:0]   result_o,
   output logic [4:0]                result_rd_o,
   output logic                      result_valid_o
);
   localparam int VW = LANE_W*LANES;
   localparam int IW = $clog2(LANES);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [VW-1:0]   opa_q, opa_d, opb_q, opb_d, acc_q, acc_d, result_q, result_d;
   logic [2:0]      op_q, op_d;
   logic [4:0]      rd_q, rd_d, result_rd_q, result_rd_d;
   logic            run, last;
   assign run            = state_q == RUN;
   assign last           = idx_q == IW'(LANES-1);
   assign lane_valid_o   = run;
   assign stall_o        = run;
   assign lane_a_o       = run ? opa_q[idx_q*LANE_W +: LANE_W] : '0;
   assign lane_b_o       = run ? opb_q[idx_q*LANE_W +: LANE_W] : '0;
   assign lane_op_o      = run ? op_q : '0;
   assign result_valid_o = state_q == DONE;
   assign result_o       = result_q;
   assign result_rd_o    = result_rd_q;
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      op_d        = op_q;
      rd_d        = rd_q;
      acc_d       = acc_q;
      result_d    = result_q;
      result_rd_d = result_rd_q;
      if (flush_i) begin
         state_d = IDLE;
         idx_d   = '0;
      end else if (run) begin
         acc_d[idx_q*LANE_W +: LANE_W] = lane_result_i;
         idx_d = last ? '0 : idx_q + 1'b1;
         if (last) begin
            state_d     = DONE;
            result_d    = acc_d;
            result_rd_d = rd_q;
         end
      end else begin
         // IDLE and DONE both accept a new op, giving back-to-back issue
         state_d = start_i ? RUN : IDLE;
         idx_d   = '0;
         if (start_i) begin
            opa_d = vrs1_i;
            opb_d = vrs2_i;
            op_d  = aluop_i;
            rd_d  = rd_i;
         end
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         op_q        <= '0;
         rd_q        <= '0;
         acc_q       <= '0;
         result_q    <= '0;
         result_rd_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         op_q        <= op_d;
         rd_q        <= rd_d;
         acc_q       <= acc_d;
         result_q    <= result_d;
         result_rd_q <= result_rd_d;
      end
   end
endmodule

// File: tb/tb_vector_lane_sequencer.sv
// tb_vector_lane_sequencer: table-driven directed sequences plus randomized traffic,
// checked against a lane-array reference model of the sequencer.
module tb_vector_lane_sequencer;
   logic         clk = 1'b0;
   logic         rst;
   logic         start_i, flush_i;
   logic [255:0] vrs1_i, vrs2_i;
   logic [2:0]   aluop_i;
   logic [4:0]   rd_i;
   logic [31:0]  lane_a_o, lane_b_o, lane_result_i;
   logic [2:0]   lane_op_o;
   logic         lane_valid_o, stall_o, result_valid_o;
   logic [255:0] result_o;
   logic [4:0]   result_rd_o;
   int           checks = 0, errors = 0;

   vector_lane_sequencer dut (
      .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
      .vrs1_i(vrs1_i), .vrs2_i(vrs2_i), .aluop_i(aluop_i), .rd_i(rd_i),
      .lane_a_o(lane_a_o), .lane_b_o(lane_b_o), .lane_op_o(lane_op_o),
      .lane_valid_o(lane_valid_o), .lane_result_i(lane_result_i), .stall_o(stall_o),
      .result_o(result_o), .result_rd_o(result_rd_o), .result_valid_o(result_valid_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'd0: return a + b;
         3'd1: return a - b;
         3'd2: return a & b;
         3'd3: return a | b;
         3'd4: return a ^ b;
         3'd5: return a << b[4:0];
         3'd6: return a >> b[4:0];
         default: return a * 3 + b;
      endcase
   endfunction

   assign lane_result_i = alu(lane_op_o, lane_a_o, lane_b_o);

   // Reference model: m_pos = 0 when not running, else 1 + lane currently presented
   int          m_pos;
   bit          m_done;
   logic [31:0] m_a[8], m_b[8], m_acc[8];
   logic [2:0]  m_op;
   logic [4:0]  m_rd, m_rdo;
   logic [255:0] m_res;

   task automatic model_reset();
      m_pos = 0; m_done = 0; m_op = 0; m_rd = 0; m_rdo = 0; m_res = '0;
      for (int k = 0; k < 8; k++) begin m_a[k] = 0; m_b[k] = 0; m_acc[k] = 0; end
   endtask

   task automatic model_step();
      if (flush_i) begin
         m_pos = 0; m_done = 0;
      end else if (m_pos != 0) begin
         m_acc[m_pos-1] = alu(m_op, m_a[m_pos-1], m_b[m_pos-1]);
         if (m_pos == 8) begin
            m_pos = 0; m_done = 1; m_rdo = m_rd;
            for (int k = 0; k < 8; k++) m_res[k*32 +: 32] = m_acc[k];
         end else m_pos++;
      end else begin
         m_done = 0;
         if (start_i) begin
            m_pos = 1; m_op = aluop_i; m_rd = rd_i;
            for (int k = 0; k < 8; k++) begin m_a[k] = vrs1_i[k*32 +: 32]; m_b[k] = vrs2_i[k*32 +: 32]; end
         end
      end
   endtask

   task automatic chk(input string n, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic model_check();
      chk("lane_valid", 256'(lane_valid_o), 256'(m_pos != 0));
      chk("stall", 256'(stall_o), 256'(m_pos != 0));
      chk("lane_a", 256'(lane_a_o), m_pos != 0 ? 256'(m_a[m_pos-1]) : '0);
      chk("lane_b", 256'(lane_b_o), m_pos != 0 ? 256'(m_b[m_pos-1]) : '0);
      chk("lane_op", 256'(lane_op_o), m_pos != 0 ? 256'(m_op) : '0);
      chk("result_valid", 256'(result_valid_o), 256'(m_done));
      chk("result", result_o, m_res);
      chk("result_rd", 256'(result_rd_o), 256'(m_rdo));
   endtask

   task automatic drive(input logic s, input logic f, input logic [255:0] a, input logic [255:0] b,
                        input logic [2:0] op, input logic [4:0] rd);
      start_i = s; flush_i = f; vrs1_i = a; vrs2_i = b; aluop_i = op; rd_i = rd;
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   typedef struct {
      logic       start, flush;
      logic [2:0] op;
      logic [4:0] rd;
      logic       exp_stall, exp_rv;
   } vec_t;
   vec_t tbl[26];

   logic [255:0] pa, pb;
   int stall_cnt, rv_first, rv_second;

   initial begin
      for (int k = 0; k < 8; k++) begin pa[k*32 +: 32] = 32'(k + 1); pb[k*32 +: 32] = 32'(10 * k); end
      // Single op, back-to-back op with start held, op flushed at idx 3, then flush+start together
      for (int i = 0; i < 26; i++) begin
         tbl[i].start     = (i == 0) || (i >= 9 && i <= 17) || i == 19 || i == 24;
         tbl[i].flush     = (i == 23) || (i == 24);
         tbl[i].op        = (i >= 9 && i < 19) ? 3'd1 : 3'd0;
         tbl[i].rd        = i < 9 ? 5'd7 : (i < 19 ? 5'd9 : 5'd3);
         tbl[i].exp_stall = (i >= 1 && i <= 8) || (i >= 10 && i <= 17) || (i >= 20 && i <= 23);
         tbl[i].exp_rv    = (i == 9) || (i == 18);
      end

      model_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, 3'd0, 5'd0);
      #12;
      chk("reset_stall", 256'(stall_o), '0);
      chk("reset_lane_valid", 256'(lane_valid_o), '0);
      chk("reset_result", result_o, '0);
      chk("reset_result_valid", 256'(result_valid_o), '0);
      @(posedge clk); #1 rst = 1'b0;

      stall_cnt = 0; rv_first = -1; rv_second = -1;
      for (int i = 0; i < 26; i++) begin
         drive(tbl[i].start, tbl[i].flush, pa, pb, tbl[i].op, tbl[i].rd);
         @(negedge clk);
         model_check();
         chk($sformatf("tbl_stall[%0d]", i), 256'(stall_o), 256'(tbl[i].exp_stall));
         chk($sformatf("tbl_rv[%0d]", i), 256'(result_valid_o), 256'(tbl[i].exp_rv));
         if (i < 9 && stall_o) stall_cnt++;
         if (result_valid_o) begin
            if (rv_first < 0) rv_first = i; else if (rv_second < 0) rv_second = i;
         end
         if (i >= 1 && i <= 8) chk($sformatf("lane_a_seq[%0d]", i), 256'(lane_a_o), 256'(i));
         if (i == 9) begin
            for (int k = 0; k < 8; k++) chk($sformatf("single_lane[%0d]", k), 256'(result_o[k*32 +: 32]), 256'(11 * k + 1));
            chk("single_rd", 256'(result_rd_o), 256'(7));
         end
         if (i == 18) chk("b2b_rd", 256'(result_rd_o), 256'(9));
         if (i == 25) chk("flush_keeps_rd", 256'(result_rd_o), 256'(9));
         finish_cycle();
      end
      chk("stall_cycles", 256'(stall_cnt), 256'(8));
      chk("rv_spacing", 256'(rv_second - rv_first), 256'(9));

      // Randomized traffic; operands, op and rd change every cycle, including during RUN
      for (int i = 0; i < 400; i++) begin
         logic [255:0] ra, rb;
         for (int k = 0; k < 8; k++) begin ra[k*32 +: 32] = $urandom; rb[k*32 +: 32] = $urandom; end
         drive($urandom_range(0, 9) < 5, $urandom_range(0, 30) == 0, ra, rb, 3'($urandom), 5'($urandom));
         @(negedge clk);
         model_check();
         finish_cycle();
      end

      // Guarantee a completed op, then assert reset asynchronously mid-flight
      for (int i = 0; i < 12; i++) begin
         drive(i == 0 || i == 10, 1'b0, ~pa, pb, 3'd4, 5'd21);
         @(negedge clk);
         model_check();
         finish_cycle();
      end
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_stall", 256'(stall_o), '0);
      chk("async_rst_lane_valid", 256'(lane_valid_o), '0);
      chk("async_rst_lane_a", 256'(lane_a_o), '0);
      chk("async_rst_result", result_o, '0);
      chk("async_rst_rd", 256'(result_rd_o), '0);
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, 1'b0, pa, pb, 3'd0, 5'd1);
         @(negedge clk);
         model_check();
         finish_cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Execute-stage consumer of the decode/execute pipeline register for vector operations.
- Takes the two latched 256-bit vector operands, ALU op and destination register, and streams them lane by lane into the shared 32-bit scalar ALU.
- Reassembles the per-lane results into a 256-bit vector and presents it to the vector writeback path.
- Holds decode stalled while a vector op is in flight.

Parameters:
- LANE_W, 32, width of one lane in bits; equals the scalar ALU width.
- LANES, 8, number of lanes; vector width is LANE_W*LANES = 256.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  decode register holds a valid vector op; sampled at the rising edge.
- flush_i  in  1  synchronous abort of the in-flight op (branch redirect).
- vrs1_i  in  256  vector operand A; lane k = bits [32k+31:32k].
- vrs2_i  in  256  vector operand B; same lane mapping.
- aluop_i  in  3  ALU operation code; passed through unmodified.
- rd_i  in  5  destination vector register.
- lane_a_o  out  32  current lane of operand A to the ALU.
- lane_b_o  out  32  current lane of operand B to the ALU.
- lane_op_o  out  3  captured ALU op.
- lane_valid_o  out  1  lane outputs are valid this cycle.
- lane_result_i  in  32  ALU result; combinational, same cycle as lane_valid_o.
- stall_o  out  1  hold the decode register and upstream stages.
- result_o  out  256  assembled result vector.
- result_rd_o  out  5  destination register of result_o.
- result_valid_o  out  1  one-cycle pulse: result_o and result_rd_o are complete.

Behaviour:
- State: IDLE, RUN, DONE. Lane index idx is 0..LANES-1 and wraps to 0 after the last lane. Also held: captured operands opA/opB, op, rd.
- Reset (async, while rst=1):
  - state=IDLE, idx=0, captured registers=0.
  - result_o=0, result_rd_o=0.
  - All other outputs 0.
  - An op that is mid-flight when rst asserts is discarded; no result_valid_o is produced for it.
- IDLE:
  - lane_valid_o=0, lane_a_o/lane_b_o/lane_op_o=0, stall_o=0, result_valid_o=0.
  - At an edge with start_i=1: capture vrs1_i, vrs2_i, aluop_i, rd_i; set idx=0; go to RUN.
- RUN:
  - lane_valid_o=1, stall_o=1.
  - lane_a_o = opA lane idx, lane_b_o = opB lane idx, lane_op_o = op.
  - Each edge: write lane_result_i into the internal result lane idx, then idx++.
  - At the edge where idx==LANES-1: go to DONE, idx=0.
  - start_i is ignored. Changes on the vrs*/aluop/rd inputs have no effect.
- DONE:
  - result_valid_o=1, stall_o=0, lane_valid_o=0.
  - result_o and result_rd_o show the completed vector and rd (registered outputs, updated on the edge entering DONE).
  - Next edge with start_i=1: capture the new op and go to RUN (back-to-back, no idle bubble).
  - Next edge with start_i=0: go to IDLE.
- Latency:
  - Accept edge E0; lanes are written at E1..E(LANES).
  - result_valid_o is high for exactly the cycle after E(LANES).
  - stall_o is high for exactly LANES cycles per op.
- Hold: result_o and result_rd_o keep their value until the next completed op. They are not cleared in IDLE or by flush.
- flush_i:
  - At an edge in RUN or DONE: go to IDLE, idx=0; no result_valid_o for the flushed op.
  - Partially written lanes are discarded; result_o is unchanged.
  - flush_i has priority over start_i at the same edge.
  - In IDLE, flush_i=1 suppresses acceptance of start_i at that edge.
- Arithmetic: no width conversion. Lanes are forwarded and stored as-is, with no sign or zero extension.

Test Plan:
- Reset check: assert rst asynchronously between edges -> all outputs 0 immediately; state IDLE after release.
- Single op: opA lane k = k+1, opB lane k = 10k, op=0, rd=7, bench ALU = add.
  - result_valid_o pulses once, 8 edges after accept.
  - result_o lane k = 11k+1; result_rd_o = 7.
  - stall_o high for exactly 8 cycles.
  - lane_a_o/lane_b_o sequence follows lanes 0..7 in order.
- Back-to-back: start_i held high through DONE -> second op enters RUN with no IDLE cycle; the two result_valid_o pulses are 9 cycles apart and each carries its own rd.
- Flush: flush_i at the edge where idx=3 -> IDLE next cycle, stall_o=0, no result_valid_o; result_o keeps the previous op's value.
- Simultaneous flush and start: flush_i=1 and start_i=1 at the same edge -> no op accepted; state stays/returns IDLE.
- Input isolation: toggle vrs1_i, vrs2_i, rd_i and start_i every cycle during RUN -> lane outputs and final result match only the captured operands.
